// File: rtl/ecg_sample_streamer.sv
// UART-byte to fixed-rate ECG sample source: little-endian assembler, sample FIFO, tick-paced FILL/RUN release.
// Define ECG_STREAMER_HOLD_LAST_EN to keep the data_valid strobe on underrun ticks (repeats last value).
module ecg_sample_streamer #(
  parameter int DATA_W       = 11,
  parameter int FIFO_DEPTH   = 16,
  parameter int SAMPLE_DIV   = 100000,
  parameter int BYTE_TIMEOUT = 50000
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               ce,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  input  logic                               clr_flags,
  output logic [DATA_W-1:0]                  ecg_value,
  output logic                               data_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               running,
  output logic                               overflow,
  output logic                               underrun
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int TO_W   = $clog2(BYTE_TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BYTE_TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_HALF  = LVL_W'(FIFO_DEPTH / 2);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Byte assembler
  logic              asm_high_q, asm_high_d;
  logic [7:0]        low_byte_q, low_byte_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              push_req;
  logic [DATA_W-1:0] push_data;

  // Tick counter
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fifo_empty, fifo_full;
  logic              push_ok, pop;

  // Sequencer, outputs and flags
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] ecg_value_q;
  logic              data_valid_q, data_valid_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;
  logic              overflow_set, underrun_set;

  // High byte only contributes its low DATA_W-8 bits; the rest is ignored.
  assign push_data = {rx_data[DATA_W-9:0], low_byte_q};

  always_comb begin
    asm_high_d = asm_high_q;
    low_byte_d = low_byte_q;
    to_cnt_d   = to_cnt_q;
    push_req   = 1'b0;
    if (rx_valid) begin
      if (asm_high_q) begin
        push_req   = 1'b1;
        asm_high_d = 1'b0;
      end else begin
        low_byte_d = rx_data;
        asm_high_d = 1'b1;
        to_cnt_d   = '0;
      end
    end else if (asm_high_q) begin
      if (to_cnt_q == TO_LAST) begin
        asm_high_d = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign tick = ce && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (ce) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    underrun_set = 1'b0;
    data_valid_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (tick) begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          data_valid_d = 1'b1;
        end else begin
          underrun_set = 1'b1;
          state_d      = ST_FILL;
`ifdef ECG_STREAMER_HOLD_LAST_EN
          data_valid_d = 1'b1;
`endif
        end
      end
    end else if (ce && (level_q >= LVL_HALF)) begin
      state_d = ST_RUN;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok      = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  assign overflow_d = overflow_set | (overflow_q & ~clr_flags);
  assign underrun_d = underrun_set | (underrun_q & ~clr_flags);

  always_ff @(posedge clk) begin
    if (nrst && push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      asm_high_q   <= 1'b0;
      low_byte_q   <= '0;
      to_cnt_q     <= '0;
      tick_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= ST_FILL;
      ecg_value_q  <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      asm_high_q   <= asm_high_d;
      low_byte_q   <= low_byte_d;
      to_cnt_q     <= to_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
      if (pop) begin
        ecg_value_q <= mem[rd_ptr_q];
      end
    end
  end

  assign ecg_value  = ecg_value_q;
  assign data_valid = data_valid_q;
  assign fifo_level = level_q;
  assign running    = (state_q == ST_RUN);
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ecg_sample_streamer.sv
// Directed test-plan steps followed by random traffic, each cycle compared with a queue-based reference model.
module tb_ecg_sample_streamer;

  localparam int DW      = 11;
  localparam int DEPTH   = 8;
  localparam int DIV     = 4;
  localparam int BTO     = 20;
  localparam int MASK_HI = (1 << (DW - 8)) - 1;
  localparam int LW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          nrst;
  logic          ce;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clr_flags;
  logic [DW-1:0] ecg_value;
  logic          data_valid;
  logic [LW-1:0] fifo_level;
  logic          running;
  logic          overflow;
  logic          underrun;

  always #5 clk = ~clk;

  ecg_sample_streamer #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SAMPLE_DIV(DIV), .BYTE_TIMEOUT(BTO)
  ) dut (
    .clk(clk), .nrst(nrst), .ce(ce), .rx_data(rx_data), .rx_valid(rx_valid),
    .clr_flags(clr_flags), .ecg_value(ecg_value), .data_valid(data_valid),
    .fifo_level(fifo_level), .running(running), .overflow(overflow), .underrun(underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int mq[$];
  int m_pend  = -1;
  int m_idle  = 0;
  int m_phase = 0;
  bit m_run   = 1'b0;
  bit m_dv    = 1'b0;
  bit m_ov    = 1'b0;
  bit m_un    = 1'b0;
  int m_val   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  old_size = mq.size();
    bit  tick;
    bit  has_sample = 1'b0;
    int  sample = 0;
    bit  ov_set = 1'b0;
    bit  un_set = 1'b0;
    if (!nrst) begin
      mq.delete();
      m_pend = -1; m_idle = 0; m_phase = 0;
      m_run = 1'b0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_val = 0;
      return;
    end
    tick = ce && (m_phase == DIV - 1);
    if (ce) m_phase = (m_phase + 1) % DIV;
    if (rx_valid) begin
      if (m_pend >= 0) begin
        has_sample = 1'b1;
        sample = ((int'(rx_data) & MASK_HI) << 8) | m_pend;
        m_pend = -1;
      end else begin
        m_pend = int'(rx_data);
        m_idle = 0;
      end
    end else if (m_pend >= 0) begin
      m_idle++;
      if (m_idle == BTO) m_pend = -1;
    end
    m_dv = 1'b0;
    if (m_run) begin
      if (tick) begin
        if (old_size > 0) begin
          m_val = mq.pop_front();
          m_dv  = 1'b1;
        end else begin
          un_set = 1'b1;
          m_run  = 1'b0;
`ifdef ECG_STREAMER_HOLD_LAST_EN
          m_dv   = 1'b1;
`endif
        end
      end
    end else if (ce && old_size >= DEPTH / 2) begin
      m_run = 1'b1;
    end
    if (has_sample) begin
      if (mq.size() < DEPTH) mq.push_back(sample);
      else ov_set = 1'b1;
    end
    m_ov = ov_set | (m_ov & !clr_flags);
    m_un = un_set | (m_un & !clr_flags);
  endtask

  task automatic compare_all();
    check("ecg_value",  32'(ecg_value),  32'(m_val));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("running",    32'(running),    32'(m_run));
    check("overflow",   32'(overflow),   32'(m_ov));
    check("underrun",   32'(underrun),   32'(m_un));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input int b);
    rx_valid = 1'b1;
    rx_data  = 8'(b);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_sample(input int v);
    int r = int'($urandom_range(0, 255));
    send_byte(v & 255);
    send_byte((r & ~MASK_HI & 255) | ((v >> 8) & MASK_HI));
  endtask

  task automatic wait_dv(input string tag, input int exp_val);
    int k = 0;
    while (data_valid !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    check({tag, "_strobe"}, 32'(data_valid), 32'd1);
    check({tag, "_value"},  32'(ecg_value),  32'(exp_val));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ecg"},   32'(ecg_value),  32'd0);
    check({tag, "_dv"},    32'(data_valid), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_run"},   32'(running),    32'd0);
    check({tag, "_ov"},    32'(overflow),   32'd0);
    check({tag, "_un"},    32'(underrun),   32'd0);
  endtask

  initial begin
    nrst = 1'b0; ce = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; clr_flags = 1'b0;
    step();
    step();
    check_reset_state("reset");
    nrst = 1'b1;

    // Prefill and run: 8 samples, drained in order, then underrun
    ce = 1'b1;
    for (int v = 1; v <= 8; v++) send_sample(v);
    idle(50);
    check("prefill_underrun", 32'(underrun), 32'd1);
    check("prefill_stopped",  32'(running),  32'd0);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);

    // Width masking: 0xAB, 0xFD -> 0x5AB
    send_byte(8'hAB);
    send_byte(8'hFD);
    for (int i = 0; i < 3; i++) send_sample(int'($urandom_range(0, 2047)));
    wait_dv("mask", 32'h5AB);
    idle(40);

    // Timeout drops a lone low byte
    send_byte(8'h12);
    idle(BTO);
    send_byte(8'h34);
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_sample(int'($urandom_range(0, 2047)));
    wait_dv("timeout", 32'h134);
    idle(40);

    // Overflow with ce held low
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    ce = 1'b0;
    for (int i = 0; i < 9; i++) send_sample(16'h100 + i);
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_flag",  32'(overflow),   32'd1);
    ce = 1'b1;
    idle(50);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-stream with queued samples and a half byte
    ce = 1'b0;
    for (int i = 0; i < 5; i++) send_sample(int'($urandom_range(0, 2047)));
    send_byte(8'h55);
    nrst = 1'b0; step(); nrst = 1'b1;
    check_reset_state("midreset");
    send_byte(8'h66);
    send_byte(8'h02);
    check("fresh_sample_level", 32'(fifo_level), 32'd1);
    ce = 1'b1;
    idle(30);

    // Random traffic with varying byte density
    for (int seg = 0; seg < 40; seg++) begin
      int dens = int'($urandom_range(1, 8));
      int len  = int'($urandom_range(40, 120));
      for (int c = 0; c < len; c++) begin
        rx_valid  = (int'($urandom_range(0, 15)) < dens * 2);
        rx_data   = 8'($urandom);
        ce        = ($urandom_range(0, 9) != 0);
        clr_flags = ($urandom_range(0, 39) == 0);
        nrst      = ($urandom_range(0, 999) != 0);
        step();
      end
      rx_valid = 1'b0; clr_flags = 1'b0; nrst = 1'b1;
    end
    ce = 1'b1;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
